cmp_bitmap_loader: RTL and testbench

- Upstream feeder for the compare accelerator (cmpacc).
- Fetches one 1536-bit glyph bitmap from word-addressed memory as 48 sequential 32-bit reads and assembles it into a wide register.
- Presents the assembled bitmap with a one-cycle wren pulse, then waits for the accelerator's done and captures its 16-bit result.
- Sits between the note-recognition controller (start/base address) and cmpacc (bitmap/wren in, result/done out).

---
 rtl/cmp_bitmap_loader_if.sv | 29 ++
 rtl/cmp_bitmap_loader.sv | 116 +++++++++++
 tb/tb_cmp_bitmap_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_bitmap_loader_if.sv
// Bus bundle between the bitmap loader, word-addressed memory and the compare accelerator.
// master = loader side, slave = memory/cmpacc side.
`timescale 1ns/1ps
interface cmp_bitmap_loader_if #(
   parameter int WORD_W = 32,
   parameter int NWORDS = 48,
   parameter int ADDR_W = 16
);
   localparam int BMP_W = WORD_W * NWORDS;

   logic              mem_rden;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic [BMP_W-1:0]  bitmap;
   logic              wren;
   logic [15:0]       cmp_result;
   logic              cmp_done;

   modport master (
      output mem_rden, mem_addr, bitmap, wren,
      input  mem_rdata, mem_rvalid, cmp_result, cmp_done
   );

   modport slave (
      input  mem_rden, mem_addr, bitmap, wren,
      output mem_rdata, mem_rvalid, cmp_result, cmp_done
   );
endinterface

// File: rtl/cmp_bitmap_loader.sv
// Fetches a glyph bitmap word by word, hands it to cmpacc with a wren strobe,
// then waits for cmp_done and holds the returned score.
`timescale 1ns/1ps
module cmp_bitmap_loader #(
   parameter int WORD_W = 32,
   parameter int NWORDS = 48,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic [15:0]       result,
   output logic              result_valid,
   cmp_bitmap_loader_if.master bus
);
   localparam int BMP_W = WORD_W * NWORDS;
   localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE,
      S_CMP,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [BMP_W-1:0]   bitmap_q, bitmap_d;
   logic [15:0]        result_q, result_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         bitmap_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         bitmap_q <= bitmap_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      bitmap_d     = bitmap_q;
      result_d     = result_q;
      bus.mem_rden = 1'b0;
      bus.wren     = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            busy         = 1'b1;
            bus.mem_rden = 1'b1;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            // Single outstanding request, so any rvalid here belongs to word cnt_q.
            if (bus.mem_rvalid) begin
               bitmap_d[int'(cnt_q)*WORD_W +: WORD_W] = bus.mem_rdata;
               if (cnt_q == LAST_WORD) begin
                  state_d = S_WRITE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_WRITE: begin
            busy     = 1'b1;
            bus.wren = 1'b1;
            state_d  = S_CMP;
         end
         S_CMP: begin
            busy = 1'b1;
            if (bus.cmp_done) begin
               result_d = bus.cmp_result;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            result_valid = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Address arithmetic wraps naturally at 2^ADDR_W.
   assign bus.mem_addr = addr_q + ADDR_W'(cnt_q);
   assign bus.bitmap   = bitmap_q;
   assign result       = result_q;
endmodule

// File: tb/tb_cmp_bitmap_loader.sv
// Directed/randomized bench for cmp_bitmap_loader with a behavioural memory and cmpacc model.
`timescale 1ns/1ps
module tb_cmp_bitmap_loader;
   localparam int WORD_W = 32;
   localparam int NWORDS = 48;
   localparam int ADDR_W = 16;
   localparam int BMP_W  = WORD_W * NWORDS;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              busy;
   logic [15:0]       result;
   logic              result_valid;

   cmp_bitmap_loader_if #(.WORD_W(WORD_W), .NWORDS(NWORDS), .ADDR_W(ADDR_W)) bus ();

   cmp_bitmap_loader #(.WORD_W(WORD_W), .NWORDS(NWORDS), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .bus          (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Memory contents: fixed pattern or a seeded hash of the address.
   bit          pat;
   logic [31:0] seed;

   logic [15:0]      got_addrs[$];
   int               n_wren, wren_cyc, n_rv, rv_cyc, done_cyc, ovl, stray;
   bit               timed_out, rv_busy;
   logic [15:0]      rv_result;
   logic [BMP_W-1:0] bmp_at_wren, basic_bmp;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (pat) return {16'hA5A5, a};
      return ({16'h0, a} * 32'h9E3779B1) ^ seed;
   endfunction

   function automatic logic [BMP_W-1:0] exp_bitmap(input logic [15:0] base);
      logic [BMP_W-1:0] r;
      r = '0;
      for (int k = 0; k < NWORDS; k++) r[k*WORD_W +: WORD_W] = mem_word(base + 16'(k));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bmp(input string tag, input logic [BMP_W-1:0] obs, input logic [BMP_W-1:0] exp);
      int w;
      w = 0;
      for (int k = NWORDS - 1; k >= 0; k--)
         if (obs[k*WORD_W +: WORD_W] !== exp[k*WORD_W +: WORD_W]) w = k;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: word %0d observed=%h expected=%h", tag, w,
                obs[w*WORD_W +: WORD_W], exp[w*WORD_W +: WORD_W]);
      end
   endtask

   // One start-to-finish transaction; cyc counts cycles after the start cycle.
   task automatic run_txn(input logic [15:0] base, input int lat_mode, input int busy_word,
                          input int rst_word, input int done_dly, input logic [15:0] cres);
      int pend, nreq, lat_idx, done_cnt;
      logic [15:0] pend_addr;
      got_addrs.delete();
      n_wren = 0; wren_cyc = -1; n_rv = 0; rv_cyc = -1; done_cyc = -1; ovl = 0; stray = 0;
      timed_out = 1'b0; rv_busy = 1'b1; rv_result = '0;
      pend = -1; nreq = 0; lat_idx = 0; done_cnt = -1; pend_addr = '0;
      start = 1'b1; base_addr = base;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 16'($urandom);
      for (int cyc = 1; cyc < 3000; cyc++) begin
         bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
         bus.cmp_done = 1'b0; bus.cmp_result = 16'($urandom); start = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.mem_rvalid = 1'b1; bus.mem_rdata = mem_word(pend_addr); pend = -1;
            end
         end
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               bus.cmp_done = 1'b1; bus.cmp_result = cres; done_cyc = cyc; done_cnt = -1;
            end
         end
         if (bus.mem_rden) begin
            if (pend != -1 || bus.mem_rvalid) ovl++;
            got_addrs.push_back(bus.mem_addr);
            pend_addr = bus.mem_addr;
            case (lat_mode)
               0:       pend = 1;
               1:       pend = (lat_idx % 3 == 0) ? 1 : ((lat_idx % 3 == 1) ? 3 : 7);
               default: pend = int'($urandom_range(1, 6));
            endcase
            lat_idx++;
            if (nreq == busy_word) begin
               start = 1'b1; base_addr = 16'h0200;
            end
            if (nreq == rst_word) begin
               rst = 1'b1;
               #1;
               chk("rst_busy", 64'(busy), 64'd0);
               chk("rst_rden", 64'(bus.mem_rden), 64'd0);
               chk("rst_wren", 64'(bus.wren), 64'd0);
               chk("rst_rvalid_out", 64'(result_valid), 64'd0);
               chk("rst_result", 64'(result), 64'd0);
               chk("rst_addr", 64'(bus.mem_addr), 64'd0);
               chk_bmp("rst_bitmap", bus.bitmap, '0);
               @(posedge clk); #1;
               rst = 1'b0;
               // Late read data for the aborted request arrives in IDLE.
               bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
               for (int j = 0; j < 12; j++) begin
                  @(posedge clk); #1;
                  bus.mem_rvalid = 1'b0;
                  if (bus.mem_rden || bus.wren || busy || result_valid) stray++;
               end
               return;
            end
            nreq++;
         end
         if (bus.wren) begin
            n_wren++; wren_cyc = cyc; bmp_at_wren = bus.bitmap; done_cnt = done_dly;
            // A done coinciding with wren must not be taken as the result.
            bus.cmp_done = 1'b1; bus.cmp_result = 16'hDEAD;
         end
         if (result_valid) begin
            n_rv++; rv_cyc = cyc; rv_busy = busy; rv_result = result;
         end
         if (n_rv > 0 && cyc >= rv_cyc + 3) break;
         @(posedge clk); #1;
      end
      bus.mem_rvalid = 1'b0; bus.cmp_done = 1'b0;
      if (n_rv == 0) timed_out = 1'b1;
   endtask

   task automatic check_txn(input string tag, input logic [15:0] base, input int done_dly,
                            input logic [15:0] cres);
      int aerr;
      aerr = 0;
      for (int k = 0; k < got_addrs.size(); k++)
         if (got_addrs[k] !== base + 16'(k)) aerr++;
      chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
      chk({tag, "_nreq"}, 64'(got_addrs.size()), 64'(NWORDS));
      chk({tag, "_addr_err"}, 64'(aerr), 64'd0);
      chk({tag, "_overlap"}, 64'(ovl), 64'd0);
      chk({tag, "_nwren"}, 64'(n_wren), 64'd1);
      chk({tag, "_nrv"}, 64'(n_rv), 64'd1);
      chk_bmp({tag, "_bitmap"}, bmp_at_wren, exp_bitmap(base));
      chk({tag, "_rv_lat"}, 64'(rv_cyc), 64'(wren_cyc + done_dly + 1));
      chk({tag, "_rv_result"}, 64'(rv_result), 64'(cres));
      chk({tag, "_rv_busy"}, 64'(rv_busy), 64'd0);
      chk({tag, "_held_result"}, 64'(result), 64'(cres));
   endtask

   initial begin
      logic [15:0] b, r;
      int d;
      rst = 1'b1; start = 1'b0; base_addr = '0;
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.cmp_done = 1'b0; bus.cmp_result = '0;
      seed = $urandom; pat = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rden", 64'(bus.mem_rden), 64'd0);
      chk("reset_wren", 64'(bus.wren), 64'd0);
      chk("reset_result_valid", 64'(result_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk_bmp("reset_bitmap", bus.bitmap, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic load, latency 1; wren in cycle 98 counting the start cycle as cycle 1.
      run_txn(16'h0100, 0, -1, -1, 5, 16'h03E7);
      check_txn("basic", 16'h0100, 5, 16'h03E7);
      chk("basic_wren_cycle", 64'(wren_cyc), 64'd97);
      chk("basic_word0", 64'(bmp_at_wren[31:0]), 64'hA5A5_0100);
      chk("basic_word47", 64'(bmp_at_wren[1535:1504]), 64'hA5A5_012F);
      chk("basic_done_dly", 64'(done_cyc), 64'(wren_cyc + 5));
      basic_bmp = bmp_at_wren;

      // Stray cmp_done and mem_rvalid while IDLE.
      bus.cmp_done = 1'b1; bus.cmp_result = 16'h1234;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.cmp_done = 1'b0; bus.mem_rvalid = 1'b0;
      @(posedge clk); #1;
      chk("idle_done_result", 64'(result), 64'h03E7);
      chk("idle_done_rv", 64'(result_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk_bmp("idle_rvalid_bitmap", bus.bitmap, basic_bmp);

      // Variable latency 1/3/7.
      run_txn(16'h0100, 1, -1, -1, 3, 16'h0042);
      check_txn("varlat", 16'h0100, 3, 16'h0042);
      chk_bmp("varlat_same_bitmap", bmp_at_wren, basic_bmp);

      // Address wrap with hashed memory contents.
      pat = 1'b0;
      run_txn(16'hFFF0, 2, -1, -1, 2, 16'hBEEF);
      check_txn("wrap", 16'hFFF0, 2, 16'hBEEF);
      if (got_addrs.size() > 16) chk("wrap_addr16", 64'(got_addrs[16]), 64'h0000);
      else chk("wrap_addr16_present", 64'(got_addrs.size()), 64'd17);
      chk("wrap_word16", 64'(bmp_at_wren[16*WORD_W +: WORD_W]), 64'(mem_word(16'h0000)));

      // Second start during word 10 is ignored.
      pat = 1'b1;
      r = 16'($urandom);
      run_txn(16'h0100, 0, 10, -1, 4, r);
      check_txn("busy_start", 16'h0100, 4, r);
      chk("busy_start_wren_cycle", 64'(wren_cyc), 64'd97);
      if (got_addrs.size() > 10) chk("busy_start_addr10", 64'(got_addrs[10]), 64'h010A);
      else chk("busy_start_addr10_present", 64'(got_addrs.size()), 64'd11);

      // Reset during word 20, then a clean load from 0x0300.
      run_txn(16'h0100, 0, -1, 20, 5, 16'h5555);
      chk("rst_nreq", 64'(got_addrs.size()), 64'd21);
      chk("rst_no_wren", 64'(n_wren), 64'd0);
      chk("rst_stray_activity", 64'(stray), 64'd0);
      chk("rst_idle_result", 64'(result), 64'd0);
      pat = 1'b0; seed = $urandom;
      run_txn(16'h0300, 2, -1, -1, 6, 16'h7A7A);
      check_txn("post_rst", 16'h0300, 6, 16'h7A7A);

      // Randomized transactions.
      for (int t = 0; t < 3; t++) begin
         seed = $urandom; pat = 1'b0;
         b = 16'($urandom); r = 16'($urandom); d = int'($urandom_range(1, 8));
         run_txn(b, 2, -1, -1, d, r);
         check_txn("random", b, d, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
